// File: rtl/seg_display_driver.sv
// -----------------------------------------------------------------------------
// seg_display_driver
//
// Purpose:
//   Latches a 32-bit value from the connector's SEG write port and shows it
//   as 8 hex digits on a common-anode 7-segment display, time-multiplexing
//   one digit per scan slot. Digit 0 is the rightmost digit (value[3:0]).
//   Each slot starts with a short all-anodes-off window to avoid ghosting.
//   Both board-facing outputs are registered.
//
// Parameters:
//   SCAN_DIV      clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  cycles at the start of each slot with all anodes off
//                 (< SCAN_DIV)
//   LZ_BLANK      1 = suppress leading zeros (digit 0 is always shown)
//
// Ports:
//   CLK     in   1   system clock
//   RST     in   1   asynchronous reset, active-high
//   SEG_WE  in   1   write strobe, one cycle per store
//   SEG_WD  in   32  write data, 8 packed hex nibbles
//   SEG_AN  out  8   digit anodes, active-low, bit i = digit i
//   SEG_CA  out  8   cathodes, active-low: [0]=a .. [6]=g, [7]=dp
// -----------------------------------------------------------------------------
module seg_display_driver #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned LZ_BLANK     = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SEG_WE,
    input  logic [31:0] SEG_WD,
    output logic [7:0]  SEG_AN,
    output logic [7:0]  SEG_CA
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);

    // Hex digit to active-low segment pattern, dp held off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // State
    logic [31:0]     value_q, value_d;
    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]      dig_idx_q, dig_idx_d;
    logic [7:0]      an_q, an_d;
    logic [7:0]      ca_q, ca_d;

    // Per-digit leading-zero suppression flags
    logic [7:0] lz_sup;
    logic [3:0] cur_nib;
    logic       slot_wrap;
    logic       in_blank;

    // Writes only touch the value; the scan runs independently of them.
    always_comb begin
        value_d = value_q;
        if (SEG_WE) begin
            value_d = SEG_WD;
        end
    end

    always_comb begin
        slot_wrap = (div_cnt_q == CntMax);
        div_cnt_d = slot_wrap ? '0 : div_cnt_q + CntW'(1);
        dig_idx_d = slot_wrap ? dig_idx_q + 3'd1 : dig_idx_q;
    end

    // Digit i > 0 is a leading zero when every nibble from i upward is zero.
    always_comb begin
        lz_sup = 8'h00;
        if (LZ_BLANK != 0) begin
            for (int i = 1; i < 8; i++) begin
                lz_sup[i] = ((value_q >> (4 * i)) == 32'd0);
            end
        end
    end

    always_comb begin
        cur_nib  = value_q[{dig_idx_q, 2'b00} +: 4];
        in_blank = (div_cnt_q < BlankEnd);
        an_d     = 8'hFF;
        ca_d     = 8'hFF;
        if (!in_blank && !lz_sup[dig_idx_q]) begin
            an_d = ~(8'b1 << dig_idx_q);
            ca_d = hex_to_seg(cur_nib);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value_q   <= '0;
            div_cnt_q <= '0;
            dig_idx_q <= '0;
            an_q      <= 8'hFF;
            ca_q      <= 8'hFF;
        end else begin
            value_q   <= value_d;
            div_cnt_q <= div_cnt_d;
            dig_idx_q <= dig_idx_d;
            an_q      <= an_d;
            ca_q      <= ca_d;
        end
    end

    assign SEG_AN = an_q;
    assign SEG_CA = ca_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_display_driver
//
// Two instances share clock, reset and write port: u_dut0 shows all digits,
// u_dut1 suppresses leading zeros. A reference model derives the expected
// display from the number of clock edges since reset and the stored value.
// -----------------------------------------------------------------------------
module tb_seg_display_driver;

    localparam int unsigned ScanDiv  = 4;
    localparam int unsigned BlankCyc = 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SEG_WE = 1'b0;
    logic [31:0] SEG_WD = 32'd0;
    logic [7:0]  an0, ca0, an1, ca1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    seg_display_driver #(
        .SCAN_DIV    (ScanDiv),
        .BLANK_CYCLES(BlankCyc),
        .LZ_BLANK    (0)
    ) u_dut0 (
        .CLK   (CLK),
        .RST   (RST),
        .SEG_WE(SEG_WE),
        .SEG_WD(SEG_WD),
        .SEG_AN(an0),
        .SEG_CA(ca0)
    );

    seg_display_driver #(
        .SCAN_DIV    (ScanDiv),
        .BLANK_CYCLES(BlankCyc),
        .LZ_BLANK    (1)
    ) u_dut1 (
        .CLK   (CLK),
        .RST   (RST),
        .SEG_WE(SEG_WE),
        .SEG_WD(SEG_WD),
        .SEG_AN(an1),
        .SEG_CA(ca1)
    );

    // ---------------- reference model ----------------
    logic [7:0] enc_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int unsigned m_cyc;
    logic [31:0] m_val;
    logic [7:0]  exp_an0, exp_ca0, exp_an1, exp_ca1;

    always @(posedge CLK or posedge RST) begin
        int unsigned ph;
        int unsigned d;
        logic [31:0] upper;
        if (RST) begin
            m_cyc   <= 0;
            m_val   <= 32'd0;
            exp_an0 <= 8'hFF;
            exp_ca0 <= 8'hFF;
            exp_an1 <= 8'hFF;
            exp_ca1 <= 8'hFF;
        end else begin
            ph    = m_cyc % ScanDiv;
            d     = (m_cyc / ScanDiv) % 8;
            upper = m_val >> (4 * d);
            if (ph < BlankCyc) begin
                exp_an0 <= 8'hFF;
                exp_ca0 <= 8'hFF;
                exp_an1 <= 8'hFF;
                exp_ca1 <= 8'hFF;
            end else begin
                exp_an0 <= ~(8'd1 << d);
                exp_ca0 <= enc_tab[upper[3:0]];
                if (d > 0 && upper == 32'd0) begin
                    exp_an1 <= 8'hFF;
                    exp_ca1 <= 8'hFF;
                end else begin
                    exp_an1 <= ~(8'd1 << d);
                    exp_ca1 <= enc_tab[upper[3:0]];
                end
            end
            if (SEG_WE) m_val <= SEG_WD;
            m_cyc <= m_cyc + 1;
        end
    end

    // ---------------- always-on invariants ----------------
    always @(negedge CLK) begin
        n_checks++;
        if ($countones(~an0) > 1 || $countones(~an1) > 1) begin
            n_fail++;
            $display("FAIL one_hot_anode: an0=%h an1=%h, required at most one low bit", an0, an1);
        end
        n_checks++;
        if (ca0[7] !== 1'b1 || ca1[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL dp_off: ca0=%h ca1=%h, required bit7=1", ca0, ca1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Return digit index of the single low anode bit, or -1 when blank.
    function automatic int lit_digit(input logic [7:0] an);
        int r = -1;
        for (int i = 0; i < 8; i++) if (an[i] === 1'b0) r = i;
        return r;
    endfunction

    task automatic write_val(input logic [31:0] v);
        @(negedge CLK);
        SEG_WE = 1'b1;
        SEG_WD = v;
        @(negedge CLK);
        SEG_WE = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int guard = 0;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (an0 !== 8'hFF || ca0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_hold: an=%h ca=%h, required FF/FF", an0, ca0);
        end
        RST = 1'b0;
        // wait for a lit digit so the async reset has something to clear
        while (an0 === 8'hFF && guard < 64) begin
            @(negedge CLK);
            guard++;
        end
        n_checks++;
        if (an0 === 8'hFF) begin
            n_fail++;
            $display("FAIL reset_prelit: an=%h, required a lit digit within 64 cycles", an0);
        end
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if (an0 !== 8'hFF || ca0 !== 8'hFF || an1 !== 8'hFF || ca1 !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_async: an0=%h ca0=%h an1=%h ca1=%h, required all FF",
                     an0, ca0, an1, ca1);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (an0 !== 8'hFF || ca0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_first_edge: an=%h ca=%h, required FF/FF", an0, ca0);
        end
        @(negedge CLK);
        n_checks++;
        if (an0 !== 8'hFE || ca0 !== 8'hC0 || an1 !== 8'hFE || ca1 !== 8'hC0) begin
            n_fail++;
            $display("FAIL reset_first_lit: an0=%h ca0=%h an1=%h ca1=%h, required FE/C0",
                     an0, ca0, an1, ca1);
        end
    endtask

    task automatic test_scan();
        int lit [8];
        int blanks = 0;
        int d;
        for (int i = 0; i < 8; i++) lit[i] = 0;
        write_val(32'h7654_3210);
        for (int c = 0; c < 32; c++) begin
            @(negedge CLK);
            d = lit_digit(an0);
            if (d < 0) begin
                blanks++;
            end else begin
                lit[d]++;
                n_checks++;
                if (ca0 !== enc_tab[d] || an0 !== ~(8'd1 << d)) begin
                    n_fail++;
                    $display("FAIL scan_digit%0d: an=%h ca=%h, required %h/%h",
                             d, an0, ca0, ~(8'd1 << d), enc_tab[d]);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (lit[i] != 3) begin
                n_fail++;
                $display("FAIL scan_lit_count%0d: got %0d cycles, required 3", i, lit[i]);
            end
        end
        n_checks++;
        if (blanks != 8) begin
            n_fail++;
            $display("FAIL scan_blank_count: got %0d, required 8", blanks);
        end
    endtask

    task automatic test_encoding();
        logic [7:0] want [8] = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        logic [7:0] seen [8];
        int d;
        for (int i = 0; i < 8; i++) seen[i] = 8'hFF;
        write_val(32'hFEDC_BA98);
        for (int c = 0; c < 32; c++) begin
            @(negedge CLK);
            d = lit_digit(an0);
            if (d >= 0) seen[d] = ca0;
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (seen[i] !== want[i]) begin
                n_fail++;
                $display("FAIL encode_digit%0d: ca=%h, required %h", i, seen[i], want[i]);
            end
        end
    endtask

    task automatic test_lz_blank();
        int lit [8];
        int d;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) lit[i] = 0;
            write_val(pass == 0 ? 32'h0000_00A0 : 32'h0);
            for (int c = 0; c < 32; c++) begin
                @(negedge CLK);
                d = lit_digit(an1);
                if (d >= 0) begin
                    lit[d]++;
                    n_checks++;
                    if (ca1 !== (d == 1 ? 8'h88 : 8'hC0)) begin
                        n_fail++;
                        $display("FAIL lz_ca_pass%0d_digit%0d: ca=%h, required %h",
                                 pass, d, ca1, (d == 1 ? 8'h88 : 8'hC0));
                    end
                end
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (lit[i] != ((i == 0 || (i == 1 && pass == 0)) ? 3 : 0)) begin
                    n_fail++;
                    $display("FAIL lz_lit_pass%0d_digit%0d: got %0d cycles, required %0d",
                             pass, i, lit[i], (i == 0 || (i == 1 && pass == 0)) ? 3 : 0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        @(negedge CLK);
        // align so the next edge is the blank cycle of the digit-0 slot
        while ((m_cyc % 32) != 0 && guard < 64) begin
            @(negedge CLK);
            guard++;
        end
        n_checks++;
        if ((m_cyc % 32) != 0) begin
            n_fail++;
            $display("FAIL b2b_align: phase=%0d, required 0 within 64 cycles", m_cyc % 32);
        end
        SEG_WE = 1'b1;
        SEG_WD = 32'h1;
        @(negedge CLK);
        SEG_WD = 32'h2;
        @(negedge CLK);
        SEG_WE = 1'b0;
        n_checks++;
        if (an0 !== 8'hFE || ca0 !== 8'hF9) begin
            n_fail++;
            $display("FAIL b2b_first: an=%h ca=%h, required FE/F9", an0, ca0);
        end
        @(negedge CLK);
        n_checks++;
        if (an0 !== 8'hFE || ca0 !== 8'hA4) begin
            n_fail++;
            $display("FAIL b2b_second: an=%h ca=%h, required FE/A4", an0, ca0);
        end
        @(negedge CLK);
        n_checks++;
        if (an0 !== 8'hFE || ca0 !== 8'hA4) begin
            n_fail++;
            $display("FAIL b2b_slot_tail: an=%h ca=%h, required FE/A4", an0, ca0);
        end
        // slot boundary must not have moved: blank, then digit 1 (value 0 -> C0)
        @(negedge CLK);
        n_checks++;
        if (an0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL b2b_phase_blank: an=%h, required FF", an0);
        end
        @(negedge CLK);
        n_checks++;
        if (an0 !== 8'hFD || ca0 !== 8'hC0) begin
            n_fail++;
            $display("FAIL b2b_phase_next: an=%h ca=%h, required FD/C0", an0, ca0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            n_checks++;
            if (an0 !== exp_an0 || ca0 !== exp_ca0) begin
                n_fail++;
                $display("FAIL rand_dut0 cyc%0d: an=%h ca=%h, required %h/%h",
                         c, an0, ca0, exp_an0, exp_ca0);
            end
            n_checks++;
            if (an1 !== exp_an1 || ca1 !== exp_ca1) begin
                n_fail++;
                $display("FAIL rand_dut1 cyc%0d: an=%h ca=%h, required %h/%h",
                         c, an1, ca1, exp_an1, exp_ca1);
            end
            if (c == 300) begin
                #($urandom_range(1, 4)) RST = 1'b1;
                #2 RST = 1'b0;
            end
            SEG_WE = ($urandom_range(0, 3) == 0);
            SEG_WD = $urandom >> $urandom_range(0, 31);
        end
        SEG_WE = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_encoding();
        test_lz_blank();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
